// File: rtl/afifo_rd_drain.sv
// ---------------------------------------------------------------------------
// afifo_rd_drain
//
// Read-side drain adapter for the asynchronous FIFO (read clock domain only).
// Pops words from a FIFO read port with one-cycle read latency and presents
// them on a valid/ready stream through a 2-entry skid buffer, so one word per
// cycle is sustained even when m_ready toggles. Delivered words are counted.
//
// Ports:
//   rdclk         in   clock, rising edge
//   arst_n        in   asynchronous active-low reset
//   fifo_empty    in   FIFO read-side empty flag
//   fifo_rd_en    out  pop request to the FIFO (combinational)
//   fifo_rd_data  in   FIFO read data, valid the cycle after a pop
//   m_valid       out  stream word available (registered)
//   m_data        out  stream word (registered head of the buffer)
//   m_ready       in   downstream accepts
//   pop_count     out  number of words delivered, wraps modulo 2^CNT_WIDTH
// ---------------------------------------------------------------------------
module afifo_rd_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rdclk,
  input  logic                  arst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  pop_count
);

  // Buffer entry 0 is always the head; entry 1 only holds data when occ = 2.
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic                  take;
  logic [2:0]            pending;

  // Pop credit: words already owned (buffered + in flight) minus the one
  // leaving this cycle must leave room for the word a pop now would return.
  always_comb begin
    take       = (occ_q != 2'd0) && m_ready;
    pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, take};
    fifo_rd_en = arst_n && !fifo_empty && (pending < 3'd2);
  end

  always_comb begin
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    occ_d      = occ_q;
    inflight_d = fifo_rd_en;
    cnt_d      = take ? (cnt_q + CNT_WIDTH'(1)) : cnt_q;

    case ({inflight_q, take})
      2'b01: begin
        // Head leaves; the second entry (if any) moves up.
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        // Returning word goes to the tail. The occ = 2 case cannot occur
        // because the pop credit forbids it; guarded to keep occ in range.
        if (occ_q == 2'd0) begin
          buf0_d = fifo_rd_data;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          buf1_d = fifo_rd_data;
          occ_d  = 2'd2;
        end
      end
      2'b11: begin
        // Write and take together: occupancy unchanged, order preserved.
        if (occ_q == 2'd1) begin
          buf0_d = fifo_rd_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge rdclk or negedge arst_n) begin
    if (!arst_n) begin
      buf0_q     <= '0;
      buf1_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

  assign m_valid   = (occ_q != 2'd0);
  assign m_data    = buf0_q;
  assign pop_count = cnt_q;

  // A returning word must always find a free slot.
  a_no_overflow: assert property (@(posedge rdclk) disable iff (!arst_n)
    !(inflight_q && !take && (occ_q == 2'd2)));

  a_occ_range: assert property (@(posedge rdclk) disable iff (!arst_n)
    occ_q != 2'd3);

endmodule

// File: tb/tb_afifo_rd_drain.sv
// ---------------------------------------------------------------------------
// tb_afifo_rd_drain
//
// Drives afifo_rd_drain from a simple array-backed FIFO with one-cycle read
// latency. A word-level model (queue of popped-but-undelivered words tagged
// with their pop cycle) predicts m_valid, m_data, fifo_rd_en and pop_count
// every cycle; directed phases add literal expectations on top.
// A second instance with CNT_WIDTH = 4 shares all inputs to observe counter
// wrap.
// ---------------------------------------------------------------------------
module tb_afifo_rd_drain;

  logic       rdclk = 1'b0;
  always #5 rdclk = ~rdclk;

  logic       arst_n;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [15:0] pop_count;

  logic       rd_en4;
  logic       m_valid4;
  logic [7:0] m_data4;
  logic [3:0] pop_count4;

  afifo_rd_drain #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .rdclk(rdclk), .arst_n(arst_n), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .pop_count(pop_count)
  );

  afifo_rd_drain #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w4 (
    .rdclk(rdclk), .arst_n(arst_n), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en4), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready),
    .pop_count(pop_count4)
  );

  // Bench FIFO: stimulus owns mem/wr_ptr/flush_to, this block owns rd_ptr.
  logic [7:0] mem [0:255];
  logic [7:0] wr_ptr;
  logic [7:0] rd_ptr;
  logic [7:0] flush_to;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge rdclk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr       <= flush_to;
      fifo_rd_data <= 8'h00;
    end else if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 8'd1;
    end
  end

  typedef struct {
    logic [7:0] d;
    int         c;
  } ent_t;

  ent_t exp_q[$];   // popped, not yet delivered
  ent_t got_q[$];   // delivered words with delivery cycle
  int   total;
  int   bad;
  int   cyc;
  int   delivered;
  int   npops;
  int   nvalid;
  int   first_pop_cyc;
  int   mark;
  logic [5:0] bp_pat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
  endtask

  // One clock cycle: apply m_ready, compare against the model, advance model.
  task automatic step(input logic rdy);
    logic       exp_valid;
    logic       exp_take;
    logic       exp_rd;
    logic       popped;
    logic [7:0] pdata;
    int         owned;
    m_ready = rdy;
    #1;
    if (!arst_n) begin
      exp_q.delete();
      delivered = 0;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_pop_count", pop_count, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      @(posedge rdclk);
      cyc++;
      @(negedge rdclk);
      return;
    end
    // A word popped in cycle N is on the stream from cycle N+2 on.
    exp_valid = (exp_q.size() > 0) && (exp_q[0].c <= cyc - 2);
    exp_take  = exp_valid && rdy;
    owned     = exp_q.size() - (exp_take ? 1 : 0);
    exp_rd    = !fifo_empty && (owned < 2);
    chk("m_valid", m_valid, exp_valid);
    if (exp_valid) chk("m_data", m_data, exp_q[0].d);
    chk("rd_en", fifo_rd_en, exp_rd);
    chk("rd_en_w4", rd_en4, exp_rd);
    chk("pop_count", pop_count, delivered % 65536);
    chk("pop_count_w4", pop_count4, delivered % 16);
    popped = fifo_rd_en && !fifo_empty;
    pdata  = mem[rd_ptr];
    nvalid += m_valid ? 1 : 0;
    @(posedge rdclk);
    if (exp_take) begin
      got_q.push_back('{exp_q[0].d, cyc});
      exp_q.pop_front();
      delivered++;
    end
    if (popped) begin
      exp_q.push_back('{pdata, cyc});
      npops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end
    cyc++;
    @(negedge rdclk);
  endtask

  initial begin
    arst_n        = 1'b0;
    m_ready       = 1'b0;
    wr_ptr        = 8'd0;
    flush_to      = 8'd0;
    total         = 0;
    bad           = 0;
    cyc           = 0;
    delivered     = 0;
    npops         = 0;
    nvalid        = 0;
    first_pop_cyc = -1;
    bp_pat        = 6'b101001;   // m_ready sequence 1,0,0,1,0,1

    // Reset held with a non-empty FIFO: no pops, all outputs cleared.
    for (int i = 0; i < 16; i++) push_word(8'(i + 1));
    @(negedge rdclk);
    repeat (3) step(1'b1);

    // Release: pop issues in the first cycle.
    arst_n = 1'b1;
    #1;
    chk("release_rd_en", fifo_rd_en, 1);
    mark = got_q.size();
    repeat (22) step(1'b1);
    chk("stream_count", got_q.size() - mark, 16);
    chk("stream_pop_count", pop_count, 16);
    if (got_q.size() >= mark + 16) begin
      for (int k = 0; k < 16; k++) chk("stream_word", got_q[mark + k].d, 8'(k + 1));
      chk("stream_latency", got_q[mark].c - first_pop_cyc, 2);
      chk("stream_consecutive", got_q[mark + 15].c - got_q[mark].c, 15);
    end

    // Backpressure with a 1,0,0,1,0,1 ready pattern.
    mark = got_q.size();
    for (int i = 0; i < 8; i++) push_word(8'hA0 + 8'(i));
    for (int i = 0; i < 30; i++) step(bp_pat[i % 6]);
    repeat (6) step(1'b1);
    chk("bp_count", got_q.size() - mark, 8);
    chk("bp_pop_count", pop_count, 24);
    if (got_q.size() >= mark + 8) begin
      for (int k = 0; k < 8; k++) chk("bp_word", got_q[mark + k].d, 8'hA0 + 8'(k));
    end

    // Single word then empty: one pop, one valid cycle.
    mark   = got_q.size();
    npops  = 0;
    nvalid = 0;
    push_word(8'h5A);
    repeat (8) step(1'b1);
    chk("empty_pops", npops, 1);
    chk("empty_valid_cycles", nvalid, 1);
    chk("empty_count", got_q.size() - mark, 1);
    if (got_q.size() > mark) chk("empty_word", got_q[mark].d, 8'h5A);
    chk("empty_pop_count", pop_count, 25);

    // Reset in the middle of a stall with a full buffer.
    for (int i = 0; i < 8; i++) push_word(8'hC0 + 8'(i));
    repeat (5) step(1'b0);
    chk("stall_valid", m_valid, 1);
    chk("stall_data", m_data, 8'hC0);
    flush_to = wr_ptr;
    arst_n   = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_m_data", m_data, 0);
    chk("midrst_rd_en", fifo_rd_en, 0);
    chk("midrst_pop_count", pop_count, 0);
    // Fresh FIFO contents: 17 words, also exercises the 4-bit counter wrap.
    for (int i = 0; i < 17; i++) push_word(8'hD0 + 8'(i));
    repeat (2) step(1'b1);
    arst_n = 1'b1;
    mark   = got_q.size();
    repeat (24) step(1'b1);
    chk("fresh_count", got_q.size() - mark, 17);
    if (got_q.size() >= mark + 17) begin
      chk("fresh_first_word", got_q[mark].d, 8'hD0);
      for (int k = 0; k < 17; k++) chk("fresh_word", got_q[mark + k].d, 8'hD0 + 8'(k));
    end
    chk("wrap_pop_count16", pop_count, 17);
    chk("wrap_pop_count4", pop_count4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
